param_sync_fifo: RTL
====================

# param_sync_fifo

Parametrised single-clock FIFO; the next generation of the team's 8×32 test FIFO. It generalises width and depth and adds independent read and write ports with simultaneous read/write, an occupancy count, programmable almost-full/almost-empty flags, registered read data with a valid strobe, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the verification-template designs and is the default buffering element for Verilator-based benches.

## Interface

Parameters:
- WIDTH, 32, data width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AFULL_LVL, DEPTH-2, almost_full asserts when count ≥ AFULL_LVL
- AEMPTY_LVL, 2, almost_empty asserts when count ≤ AEMPTY_LVL

Ports (AW = $clog2(DEPTH)):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data
- rd_en  in  1  read request
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  rd_data holds a newly popped word this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_LVL
- almost_empty  out  1  count ≤ AEMPTY_LVL
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected
- clr_err  in  1  clears overflow/underflow

## Operation

- Storage: DEPTH×WIDTH register array; write pointer wptr and read pointer rptr, each AW+1 bits (extra wrap bit); count = wptr − rptr modulo 2^(AW+1).
- Address = pointer[AW-1:0]; pointers wrap naturally from DEPTH−1 to 0 with the wrap bit toggling.
- Read accepted (rd_acc) = rd_en && !empty.
- Write accepted (wr_acc) = wr_en && (!full || rd_en). A write while full is accepted only when a read is accepted in the same cycle.
- No write-through: a read while empty is rejected even if wr_en is high in that cycle.
- On wr_acc: mem[wptr] ← wr_data, wptr ← wptr+1.
- On rd_acc: rd_data ← mem[rptr], rptr ← rptr+1, rd_valid ← 1; otherwise rd_valid ← 0 and rd_data holds its value.
- Simultaneous wr_acc and rd_acc: count unchanged, both pointers advance. When full, the read returns the oldest word and the incoming word fills the freed slot.
- overflow ← 1 when wr_en && !wr_acc; underflow ← 1 when rd_en && !rd_acc.
- clr_err clears both error flags. If a set condition and clr_err occur in the same cycle, set wins.
- Error events never modify pointers, memory or rd_data.
- Strict first-in, first-out order; data is never duplicated or dropped except for rejected writes.

## Timing

- Reset (synchronous): wptr = rptr = 0, rd_data = 0, rd_valid = 0, overflow = underflow = 0. Derived flags after reset: count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0 (for AFULL_LVL > 0). Memory contents are not reset.
- Reset asserted mid-operation discards all stored words. wr_en, rd_en and clr_err are ignored during any cycle with reset high.
- Status outputs (full, empty, almost_*, count) are combinational from the pointers only, never from wr_en/rd_en. They reflect an accepted operation one cycle after the edge that accepted it.
- Read latency: rd_data and rd_valid are valid in the cycle after the edge where rd_acc was sampled.
- Write-to-read latency: a word written at edge N into an empty FIFO can be accepted by a read at edge N+1 and appears on rd_data after edge N+1.
- Full throughput: one write and one read per cycle, sustained indefinitely.

## Test plan

- Reset then idle: outputs are count=0, empty=1, almost_empty=1, full=0, rd_valid=0, rd_data=0, overflow=underflow=0.
- Fill/drain, DEPTH=8: write 0x10..0x17 on 8 consecutive cycles → full=1, count=8, almost_full from count=6. Then read 8 times → rd_data 0x10..0x17 in order with rd_valid high each cycle after the read; ends with empty=1.
- Overflow/underflow: with FIFO full, write 0xAA → overflow=1, count stays 8, and 0xAA never appears on rd_data. Drain, then read while empty → underflow=1 with rd_data unchanged. Pulse clr_err → both flags return to 0. clr_err together with a new reject → flag stays 1.
- Simultaneous read/write: at count=3, 20 cycles of wr_en=rd_en=1 with incrementing data → count stays 3 and output order is preserved. At full, wr+rd with 0x55 → count=8 and 0x55 is read after the existing 8 words.
- Wrap-around: 3 passes of 5 writes followed by 5 reads, so both pointers cross DEPTH−1 → 0 → data matches a reference queue and count never mismatches.
- Reset mid-stream: with count=5, assert reset for 1 cycle → count=0, empty=1, rd_valid=0. A subsequent write of 0x99 followed by a read returns 0x99.

Source files
------------

// File: rtl/param_sync_fifo.sv
// param_sync_fifo
// Single-clock FIFO with parameterised width and depth. It has independent
// read and write ports that can both fire in the same cycle, and an occupancy
// count. It also provides programmable almost-full/almost-empty flags,
// registered read data with a valid strobe, and sticky overflow/underflow
// flags.
// Pointers carry one extra wrap bit, so that full and empty can be told apart
// without a separate occupancy register.

module param_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 8,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);

    // Thresholds resized to the pointer width so the compares stay same-width.
    localparam logic [AW:0] DEPTH_C  = DEPTH[AW:0];
    localparam logic [AW:0] AFULL_C  = AFULL_LVL[AW:0];
    localparam logic [AW:0] AEMPTY_C = AEMPTY_LVL[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [AW:0]      count_w;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic             wr_acc;
    logic             rd_acc;

    // Status is derived from the pointers alone, never from the request inputs.
    always_comb begin
        count_w      = wptr_q - rptr_q;
        waddr        = wptr_q[AW-1:0];
        raddr        = rptr_q[AW-1:0];
        full         = (count_w == DEPTH_C);
        empty        = (count_w == '0);
        almost_full  = (count_w >= AFULL_C);
        almost_empty = (count_w <= AEMPTY_C);
    end

    // Accept logic. A write into a full FIFO is allowed when a read frees a
    // slot in the same cycle. A read into an empty FIFO is always rejected,
    // even if a write arrives in that cycle, because there is no write-through.
    always_comb begin
        rd_acc = rd_en && !empty;
        wr_acc = wr_en && (!full || rd_en);
    end

    // Pointer advance on accepted operations.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_acc) wptr_d = wptr_q + 1'b1;
        if (rd_acc) rptr_d = rptr_q + 1'b1;
    end

    // Storage write. When the FIFO is full and a read and a write happen
    // together, the slot being written is the one the read is vacating. The
    // read takes the old word from mem_q, so the two do not collide.
    always_comb begin
        mem_d = mem_q;
        if (wr_acc) mem_d[waddr] = wr_data;
    end

    // Registered read port: capture on accept, otherwise hold data and drop valid.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        if (rd_acc) rd_data_d = mem_q[raddr];
    end

    // Sticky error flags. If a new reject and clr_err arrive together, the
    // reject wins.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && !wr_acc) overflow_d  = 1'b1;
        if (rd_en && !rd_acc) underflow_d = 1'b1;
    end

    // Control state, synchronously reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array. It is not reset, and writes are blocked while reset is high.
    always_ff @(posedge clk) begin
        if (!reset) mem_q <= mem_d;
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_w;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
